// File: rtl/core_mem_ctrl.sv
// rtl/core_mem_ctrl.sv - MEM-stage data-memory sequencer driving one L1D transaction per load/store
module core_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_val,
  input  logic        mem_req_we,
  input  logic [2:0]  mem_req_size,
  input  logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_wdata,
  input  logic [31:0] mem_cach_bound_in,
  input  logic        mem_kill,
  output logic        l1d_req_val,
  input  logic        l1d_req_ack,
  output logic [2:0]  l1d_req_cop,
  output logic [2:0]  l1d_req_size,
  output logic [31:0] l1d_req_addr,
  output logic [31:0] l1d_req_wdata,
  input  logic        l1d_resp_val,
  input  logic [31:0] l1d_resp_data,
  output logic        mem_stall,
  output logic [31:0] mem_rdata_out,
  output logic        mem_rdata_val,
  output logic        mem_err_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  // Last counter value spent waiting in RESP before declaring a timeout.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        we_q;
  logic        nc_q;
  logic        killed_q;
  logic        err_q;
  logic [7:0]  cnt_q;

  logic        illegal;
  logic        req_nc;
  logic        kill_now;

  // Decode alignment/size legality and cacheability of the incoming op.
  always_comb begin
    illegal  = (mem_req_size > 3'd2)
            || ((mem_req_size == 3'd1) && mem_req_addr[0])
            || ((mem_req_size == 3'd2) && (mem_req_addr[1:0] != 2'b00));
    req_nc   = (mem_req_addr >= mem_cach_bound_in);
    // A kill seen in the same cycle as the response still suppresses the data.
    kill_now = killed_q | mem_kill;
  end

  // Pipeline hold: asserted from acceptance until the op reaches DONE.
  always_comb begin
    mem_stall = ((state == S_IDLE) && mem_req_val && !mem_kill)
             || (state == S_REQ)
             || (state == S_RESP);
  end

  // Sequencer FSM with registered L1D request and MEM-side result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      nc_q          <= 1'b0;
      killed_q      <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= 8'd0;
      l1d_req_val   <= 1'b0;
      l1d_req_cop   <= 3'd0;
      l1d_req_size  <= 3'd0;
      l1d_req_addr  <= 32'd0;
      l1d_req_wdata <= 32'd0;
      mem_rdata_out <= 32'd0;
      mem_rdata_val <= 1'b0;
      mem_err_out   <= 1'b0;
    end else begin
      mem_rdata_val <= 1'b0;
      mem_err_out   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_req_val && !mem_kill) begin
            we_q          <= mem_req_we;
            nc_q          <= req_nc;
            killed_q      <= 1'b0;
            cnt_q         <= 8'd0;
            l1d_req_size  <= mem_req_size;
            l1d_req_addr  <= mem_req_addr;
            l1d_req_wdata <= mem_req_wdata;
            // {nc,we} maps directly onto RD/WR/RD_NC/WR_NC.
            l1d_req_cop   <= {1'b0, req_nc, mem_req_we};
            if (illegal) begin
              err_q       <= 1'b1;
              mem_err_out <= 1'b1;
              state       <= S_DONE;
            end else begin
              err_q       <= 1'b0;
              l1d_req_val <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (l1d_req_ack) begin
            // Ack beats a same-cycle kill: the transaction is already issued.
            l1d_req_val <= 1'b0;
            killed_q    <= kill_now;
            if (we_q) begin
              state <= S_DONE;
            end else begin
              cnt_q <= 8'd0;
              state <= S_RESP;
            end
          end else if (mem_kill) begin
            l1d_req_val <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_RESP: begin
          killed_q <= kill_now;
          if (l1d_resp_val) begin
            if (!kill_now) begin
              mem_rdata_out <= l1d_resp_data;
              mem_rdata_val <= 1'b1;
            end
            state <= S_DONE;
          end else if (cnt_q == TO_LAST) begin
            err_q       <= 1'b1;
            mem_err_out <= !kill_now;
            state       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = nc_q ^ err_q;

endmodule

// File: tb/tb_core_mem_ctrl.sv
// tb/tb_core_mem_ctrl.sv - directed self-checking bench for core_mem_ctrl
module tb_core_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_req_val;
  logic        mem_req_we;
  logic [2:0]  mem_req_size;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [31:0] mem_cach_bound_in;
  logic        mem_kill;
  logic        l1d_req_val;
  logic        l1d_req_ack;
  logic [2:0]  l1d_req_cop;
  logic [2:0]  l1d_req_size;
  logic [31:0] l1d_req_addr;
  logic [31:0] l1d_req_wdata;
  logic        l1d_resp_val;
  logic [31:0] l1d_resp_data;
  logic        mem_stall;
  logic [31:0] mem_rdata_out;
  logic        mem_rdata_val;
  logic        mem_err_out;

  int vectors;
  int miscompares;

  core_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_req_val       (mem_req_val),
    .mem_req_we        (mem_req_we),
    .mem_req_size      (mem_req_size),
    .mem_req_addr      (mem_req_addr),
    .mem_req_wdata     (mem_req_wdata),
    .mem_cach_bound_in (mem_cach_bound_in),
    .mem_kill          (mem_kill),
    .l1d_req_val       (l1d_req_val),
    .l1d_req_ack       (l1d_req_ack),
    .l1d_req_cop       (l1d_req_cop),
    .l1d_req_size      (l1d_req_size),
    .l1d_req_addr      (l1d_req_addr),
    .l1d_req_wdata     (l1d_req_wdata),
    .l1d_resp_val      (l1d_resp_val),
    .l1d_resp_data     (l1d_resp_data),
    .mem_stall         (mem_stall),
    .mem_rdata_out     (mem_rdata_out),
    .mem_rdata_val     (mem_rdata_val),
    .mem_err_out       (mem_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata);
    mem_req_val   = 1'b1;
    mem_req_we    = we;
    mem_req_size  = size;
    mem_req_addr  = addr;
    mem_req_wdata = wdata;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    mem_req_val = 1'b0;
    mem_req_we = 1'b0;
    mem_req_size = 3'd0;
    mem_req_addr = 32'd0;
    mem_req_wdata = 32'd0;
    mem_cach_bound_in = 32'h8000_0000;
    mem_kill = 1'b0;
    l1d_req_ack = 1'b0;
    l1d_resp_val = 1'b0;
    l1d_resp_data = 32'd0;

    // Reset state
    tick;
    tick;
    chk("rst_req_val", l1d_req_val, 0);
    chk("rst_rdata_val", mem_rdata_val, 0);
    chk("rst_err", mem_err_out, 0);
    chk("rst_cop", l1d_req_cop, 0);
    chk("rst_addr", l1d_req_addr, 0);
    chk("rst_rdata", mem_rdata_out, 0);
    chk("rst_stall", mem_stall, 0);
    rst = 1'b0;

    // Cacheable load, ack in 2nd REQ cycle, response 3 cycles after ack
    tick; op(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    #1 chk("ld_accept_stall", mem_stall, 1);
    tick; chk("ld_req_val1", l1d_req_val, 1);
    chk("ld_cop", l1d_req_cop, 0);
    chk("ld_addr", l1d_req_addr, 32'h0000_0100);
    chk("ld_size", l1d_req_size, 2);
    #1 chk("ld_req_stall", mem_stall, 1);
    tick; chk("ld_req_val2", l1d_req_val, 1);
    chk("ld_addr_stable", l1d_req_addr, 32'h0000_0100);
    l1d_req_ack = 1'b1;
    tick; l1d_req_ack = 1'b0;
    chk("ld_resp_req_val", l1d_req_val, 0);
    chk("ld_resp_rv0", mem_rdata_val, 0);
    #1 chk("ld_resp_stall", mem_stall, 1);
    tick;
    tick; l1d_resp_val = 1'b1; l1d_resp_data = 32'hDEAD_BEEF;
    tick; l1d_resp_val = 1'b0; mem_req_val = 1'b0;
    chk("ld_done_rv", mem_rdata_val, 1);
    chk("ld_done_data", mem_rdata_out, 32'hDEAD_BEEF);
    chk("ld_done_err", mem_err_out, 0);
    #1 chk("ld_done_stall", mem_stall, 0);
    tick; chk("ld_after_rv", mem_rdata_val, 0);
    chk("ld_after_data", mem_rdata_out, 32'hDEAD_BEEF);

    // Uncacheable store, immediate ack
    op(1'b1, 3'd2, 32'h8000_0010, 32'h1234_5678);
    tick; chk("st_req_val", l1d_req_val, 1);
    chk("st_cop", l1d_req_cop, 3);
    chk("st_wdata", l1d_req_wdata, 32'h1234_5678);
    chk("st_addr", l1d_req_addr, 32'h8000_0010);
    l1d_req_ack = 1'b1;
    tick; l1d_req_ack = 1'b0; mem_req_val = 1'b0;
    chk("st_done_req_val", l1d_req_val, 0);
    chk("st_done_rv", mem_rdata_val, 0);
    chk("st_done_err", mem_err_out, 0);
    #1 chk("st_done_stall", mem_stall, 0);
    tick;

    // Misaligned half at 0x101
    op(1'b0, 3'd1, 32'h0000_0101, 32'd0);
    #1 chk("mh_stall", mem_stall, 1);
    tick; mem_req_val = 1'b0;
    chk("mh_err", mem_err_out, 1);
    chk("mh_req_val", l1d_req_val, 0);
    chk("mh_rv", mem_rdata_val, 0);
    tick; chk("mh_err_clr", mem_err_out, 0);
    chk("mh_req_val2", l1d_req_val, 0);

    // Misaligned word at 0x102
    op(1'b0, 3'd2, 32'h0000_0102, 32'd0);
    tick; mem_req_val = 1'b0;
    chk("mw_err", mem_err_out, 1);
    chk("mw_req_val", l1d_req_val, 0);
    tick; chk("mw_err_clr", mem_err_out, 0);

    // Illegal size 3 on an aligned address
    op(1'b1, 3'd3, 32'h0000_0000, 32'd0);
    tick; mem_req_val = 1'b0;
    chk("sz3_err", mem_err_out, 1);
    chk("sz3_req_val", l1d_req_val, 0);
    tick;

    // Aligned byte at odd address is legal
    op(1'b0, 3'd0, 32'h0000_0103, 32'd0);
    tick; mem_kill = 1'b1;
    chk("byte_req_val", l1d_req_val, 1);
    chk("byte_err", mem_err_out, 0);
    // Kill in REQ before ack
    tick; mem_kill = 1'b0; mem_req_val = 1'b0;
    chk("kreq_req_val", l1d_req_val, 0);
    chk("kreq_rv", mem_rdata_val, 0);
    chk("kreq_err", mem_err_out, 0);
    #1 chk("kreq_stall", mem_stall, 0);
    tick; chk("kreq_rv2", mem_rdata_val, 0);
    chk("kreq_err2", mem_err_out, 0);

    // Valid with kill in IDLE is ignored
    op(1'b0, 3'd2, 32'h0000_0200, 32'd0); mem_kill = 1'b1;
    #1 chk("kidle_stall", mem_stall, 0);
    tick; mem_kill = 1'b0; mem_req_val = 1'b0;
    chk("kidle_req_val", l1d_req_val, 0);

    // Kill in the ack cycle of a load, response 2 cycles after ack
    op(1'b0, 3'd2, 32'h0000_0300, 32'd0);
    tick; l1d_req_ack = 1'b1; mem_kill = 1'b1;
    tick; l1d_req_ack = 1'b0; mem_kill = 1'b0; mem_req_val = 1'b0;
    chk("kack_req_val", l1d_req_val, 0);
    #1 chk("kack_resp_stall", mem_stall, 1);
    tick; l1d_resp_val = 1'b1; l1d_resp_data = 32'hCAFE_F00D;
    #1 chk("kack_resp_stall2", mem_stall, 1);
    tick; l1d_resp_val = 1'b0;
    chk("kack_done_rv", mem_rdata_val, 0);
    chk("kack_done_data", mem_rdata_out, 32'hDEAD_BEEF);
    chk("kack_done_err", mem_err_out, 0);
    #1 chk("kack_done_stall", mem_stall, 0);
    tick; chk("kack_after_rv", mem_rdata_val, 0);

    // Timeout with TIMEOUT=4: four RESP cycles, then DONE with err
    op(1'b0, 3'd2, 32'h0000_0400, 32'd0);
    tick; l1d_req_ack = 1'b1;
    tick; l1d_req_ack = 1'b0;
    tick;
    tick;
    tick; chk("to_last_err", mem_err_out, 0);
    #1 chk("to_last_stall", mem_stall, 1);
    tick; mem_req_val = 1'b0;
    chk("to_err", mem_err_out, 1);
    chk("to_rv", mem_rdata_val, 0);
    #1 chk("to_stall", mem_stall, 0);
    tick; l1d_resp_val = 1'b1; l1d_resp_data = 32'h5555_AAAA;
    chk("to_err_clr", mem_err_out, 0);
    tick; l1d_resp_val = 1'b0;
    chk("late_rv", mem_rdata_val, 0);
    chk("late_data", mem_rdata_out, 32'hDEAD_BEEF);
    chk("late_err", mem_err_out, 0);
    #1 chk("late_stall", mem_stall, 0);

    // Reset while waiting in RESP
    op(1'b0, 3'd2, 32'h0000_0500, 32'd0);
    tick; l1d_req_ack = 1'b1;
    tick; l1d_req_ack = 1'b0; rst = 1'b1; mem_req_val = 1'b0;
    tick; rst = 1'b0;
    chk("mrst_req_val", l1d_req_val, 0);
    chk("mrst_data", mem_rdata_out, 0);
    chk("mrst_rv", mem_rdata_val, 0);
    chk("mrst_err", mem_err_out, 0);
    chk("mrst_cop", l1d_req_cop, 0);
    chk("mrst_addr", l1d_req_addr, 0);
    #1 chk("mrst_stall", mem_stall, 0);
    // IDLE must accept a new cacheable store right away
    op(1'b1, 3'd2, 32'h0000_0010, 32'hA5A5_0001);
    #1 chk("mrst_accept_stall", mem_stall, 1);
    tick; chk("mrst_st_req_val", l1d_req_val, 1);
    chk("mrst_st_cop", l1d_req_cop, 1);
    l1d_req_ack = 1'b1;
    tick; l1d_req_ack = 1'b0; mem_req_val = 1'b0;
    chk("mrst_st_done", l1d_req_val, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_mem_ctrl.md
# core_mem_ctrl

MEM-stage data-memory sequencer for the Selen core. It sits between the MEM pipeline stage and the L1D request/response bus. For each load/store it checks alignment, classifies the address as cacheable or uncacheable, and drives one L1D transaction. It stalls the pipeline until the access completes, returns load data, and handles kills and response timeouts.

## Interface
- TIMEOUT, 255: max cycles waited in RESP for a load response before flagging an error (1..255)
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- mem_req_val  in  1  MEM stage holds a memory op
- mem_req_we  in  1  1 = store, 0 = load
- mem_req_size  in  3  0 byte, 1 half, 2 word; 3..7 illegal
- mem_req_addr  in  32  byte address (ALU result)
- mem_req_wdata  in  32  store data
- mem_cach_bound_in  in  32  addresses < bound are cacheable; >= bound are uncacheable
- mem_kill  in  1  flush of the MEM-stage op
- l1d_req_val  out  1  request valid
- l1d_req_ack  in  1  L1D accepts request this cycle
- l1d_req_cop  out  3  0 RD, 1 WR, 2 RD_NC, 3 WR_NC
- l1d_req_size  out  3  copy of latched size
- l1d_req_addr  out  32  latched address
- l1d_req_wdata  out  32  latched store data
- l1d_resp_val  in  1  load response valid
- l1d_resp_data  in  32  load response data
- mem_stall  out  1  hold pipeline (combinational)
- mem_rdata_out  out  32  load data, held until next load completes
- mem_rdata_val  out  1  one-cycle load-complete pulse
- mem_err_out  out  1  one-cycle pulse: misaligned/illegal size or timeout

## Operation
- FSM states:
  - IDLE
  - REQ
  - RESP
  - DONE
- Latched fields: we, size, addr, wdata, nc = (addr >= bound), killed flag, err flag, 8-bit timeout counter.
- IDLE:
  - If mem_req_val && !mem_kill: latch the fields.
  - Illegal (size>2, half with addr[0]=1, or word with addr[1:0]!=0): go to DONE with err=1.
  - Otherwise go to REQ.
  - mem_req_val && mem_kill: ignored, stay IDLE.
- REQ:
  - l1d_req_val=1.
  - cop = {nc,we} mapped to RD/WR/RD_NC/WR_NC.
  - On ack, store: go to DONE (stores are posted).
  - On ack, load: go to RESP with counter=0.
  - mem_kill without ack: go to IDLE; l1d_req_val drops next cycle and no transaction is issued.
  - mem_kill with ack in the same cycle: ack wins and the transaction proceeds with killed=1.
- RESP:
  - On l1d_resp_val: capture data into mem_rdata_out (only if !killed), go to DONE.
  - mem_kill here sets killed=1; the FSM still waits for the response.
  - Counter increments each cycle without a response. When it reaches TIMEOUT-1 with no response, go to DONE with err=1.
- DONE (one cycle):
  - mem_rdata_val = load && !killed && !err.
  - mem_err_out = err && !killed.
  - Next state is IDLE.
- Killed store that reached DONE: completes silently.
- l1d_resp_val outside RESP is ignored, including late responses after a timeout.
- mem_stall = (IDLE && mem_req_val && !mem_kill) || REQ || RESP.
  - Deasserted in DONE, so the pipeline advances at the end of DONE.
- Reset values:
  - state IDLE
  - l1d_req_val, mem_rdata_val, mem_err_out = 0
  - l1d_req_cop, size, addr, wdata, mem_rdata_out = 0
  - counter and all flags 0
- Reset mid-transaction returns to IDLE immediately and drops l1d_req_val in the next cycle. The L1D side is reset by the same rst.

## Timing
- All outputs except mem_stall are registered.
- Load, best case (ack at first REQ cycle, response one cycle later):
  - cycle 0: IDLE accepts
  - cycle 1: REQ with ack
  - cycle 2: RESP with resp_val
  - cycle 3: DONE with rdata_val
- Store, best case: accept in cycle 0, ack in cycle 1, DONE in cycle 2.
- Misaligned access: accept in cycle 0, DONE with err in cycle 1. No L1D request.
- Minimum back-to-back op spacing is 3 cycles (load 4), because a new op is seen in IDLE the cycle after DONE.
- l1d_req_* fields are stable while l1d_req_val=1 and ack=0.
- L1D guarantees resp_val comes at least one cycle after ack.

## Test plan
- Cacheable load:
  - Stimulus: addr=0x100, bound=0x8000_0000, size=2; ack in the 2nd REQ cycle; resp 0xDEADBEEF 3 cycles later.
  - Expect: cop=0, stall high until DONE, one rdata_val pulse with 0xDEADBEEF.
- Uncacheable store:
  - Stimulus: addr=0x8000_0010, size=2, wdata=0x1234_5678, ack immediate.
  - Expect: cop=3, DONE 2 cycles after accept, no rdata_val, no err.
- Misaligned accesses:
  - Stimulus: half at 0x101; then word at 0x102.
  - Expect: each gives err pulse 1 cycle after accept, l1d_req_val never asserted.
- Kill in REQ before ack.
  - Expect: return to IDLE, l1d_req_val falls, no rdata/err.
- Kill in the ack cycle of a load, response 2 cycles later:
  - Expect: RESP waits for the response, no rdata_val, mem_rdata_out keeps its old value.
- Timeout:
  - Stimulus: TIMEOUT=4, load acked, no response.
  - Expect: err pulse after 4 RESP cycles. A late resp_val in IDLE is ignored.
- Reset mid-flight:
  - Stimulus: assert rst in RESP.
  - Expect: next cycle state IDLE, all outputs 0.
